p4_router_ingress_dwrr_sched: RTL and testbench

Deficit-weighted round-robin (DWRR) packet scheduler for the P4 router ingress buffer read side. It replaces plain round-robin partition scanning. Each cycle it sees which ingress partitions hold at least one complete packet, plus the head packet length in words. It issues one grant at a time (port index + length) to the buffer read datapath, then waits for that packet's tlast before scheduling again. Per-port quanta let higher-rate interfaces receive proportionally more ing_bus bandwidth.

---
 rtl/p4_router_ingress_dwrr_sched.sv | 146 ++++++++++++++
 tb/tb_p4_router_ingress_dwrr_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_router_ingress_dwrr_sched.sv
// Deficit-weighted round-robin grant scheduler for the ingress buffer read side.
// Offers one (port, length) grant at a time and waits for pkt_done before scheduling again.
module p4_router_ingress_dwrr_sched #(
   parameter int unsigned NUM_PORTS     = 4,
   parameter int unsigned LEN_WIDTH     = 12,
   parameter int unsigned QUANTUM_WIDTH = 12,
   parameter int unsigned DEFICIT_WIDTH = 14,
   localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                               clk,
   input  logic                               aresetn,
   input  logic [NUM_PORTS-1:0]               pkt_avail,
   input  logic [NUM_PORTS*LEN_WIDTH-1:0]     head_len,
   input  logic [NUM_PORTS*QUANTUM_WIDTH-1:0] quantum,
   output logic                               sched_valid,
   output logic [PORT_W-1:0]                  sched_port,
   output logic [LEN_WIDTH-1:0]               sched_len,
   input  logic                               sched_ready,
   input  logic                               pkt_done,
   output logic                               proto_err
);

   localparam int unsigned MAX_IN_W = (LEN_WIDTH > QUANTUM_WIDTH) ? LEN_WIDTH : QUANTUM_WIDTH;
   localparam int unsigned SUM_W    = DEFICIT_WIDTH + 1;

   // Saturation only guarantees service if the deficit can exceed any length/quantum.
   if (DEFICIT_WIDTH <= MAX_IN_W) begin : gen_width_check
      $error("DEFICIT_WIDTH must exceed both LEN_WIDTH and QUANTUM_WIDTH");
   end

   typedef enum logic [1:0] {StArrive, StCheck, StOffer, StBusy} state_e;

   state_e                   state_q, state_d;
   logic [PORT_W-1:0]        cur_q, cur_d;
   logic [DEFICIT_WIDTH-1:0] deficit_q [NUM_PORTS];
   logic [DEFICIT_WIDTH-1:0] deficit_d [NUM_PORTS];
   logic                     valid_q, valid_d;
   logic [PORT_W-1:0]        port_q, port_d;
   logic [LEN_WIDTH-1:0]     len_q, len_d;
   logic                     err_q, err_d;

   logic [LEN_WIDTH-1:0]     len_arr [NUM_PORTS];
   logic [QUANTUM_WIDTH-1:0] quant_arr [NUM_PORTS];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : gen_unpack
      assign len_arr[p]   = head_len[p*LEN_WIDTH +: LEN_WIDTH];
      assign quant_arr[p] = quantum[p*QUANTUM_WIDTH +: QUANTUM_WIDTH];
   end

   logic                     cur_avail;
   logic [LEN_WIDTH-1:0]     cur_len;
   logic [DEFICIT_WIDTH-1:0] cur_def;
   logic [SUM_W-1:0]         def_sum;
   logic [DEFICIT_WIDTH-1:0] def_sat;
   logic                     len_fits;
   logic [PORT_W-1:0]        cur_next;

   always_comb begin
      cur_avail = pkt_avail[cur_q];
      cur_len   = len_arr[cur_q];
      cur_def   = deficit_q[cur_q];
      def_sum   = {1'b0, cur_def} + SUM_W'(quant_arr[cur_q]);
      def_sat   = def_sum[DEFICIT_WIDTH] ? {DEFICIT_WIDTH{1'b1}} : def_sum[DEFICIT_WIDTH-1:0];
      len_fits  = DEFICIT_WIDTH'(cur_len) <= cur_def;
      cur_next  = (cur_q == PORT_W'(NUM_PORTS - 1)) ? '0 : cur_q + 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      deficit_d = deficit_q;
      valid_d   = valid_q;
      port_d    = port_q;
      len_d     = len_q;
      // pkt_done is only meaningful while a granted packet is in flight.
      err_d     = pkt_done && (state_q != StBusy);

      case (state_q)
         StArrive: begin
            if (cur_avail) begin
               deficit_d[cur_q] = def_sat;
               state_d          = StCheck;
            end else begin
               deficit_d[cur_q] = '0;
               cur_d            = cur_next;
            end
         end
         StCheck: begin
            if (cur_avail && len_fits) begin
               port_d  = cur_q;
               len_d   = cur_len;
               valid_d = 1'b1;
               state_d = StOffer;
            end else begin
               if (!cur_avail) begin
                  deficit_d[cur_q] = '0;
               end
               cur_d   = cur_next;
               state_d = StArrive;
            end
         end
         StOffer: begin
            if (sched_ready) begin
               // CHECK guaranteed len_q <= deficit, so this cannot underflow.
               deficit_d[cur_q] = cur_def - DEFICIT_WIDTH'(len_q);
               valid_d          = 1'b0;
               state_d          = StBusy;
            end
         end
         StBusy: begin
            if (pkt_done) begin
               state_d = StCheck;
            end
         end
         default: state_d = StArrive;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= StArrive;
         cur_q   <= '0;
         valid_q <= 1'b0;
         port_q  <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            deficit_q[p] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         valid_q   <= valid_d;
         port_q    <= port_d;
         len_q     <= len_d;
         err_q     <= err_d;
         deficit_q <= deficit_d;
      end
   end

   assign sched_valid = valid_q;
   assign sched_port  = port_q;
   assign sched_len   = len_q;
   assign proto_err   = err_q;

endmodule

// File: tb/tb_p4_router_ingress_dwrr_sched.sv
// Directed bench for the DWRR scheduler: expected grants are queued as stimulus is set up
// and popped as the DUT offers them; grant latencies are checked in clock cycles.
module tb_p4_router_ingress_dwrr_sched;

   localparam int NP = 4;
   localparam int LW = 12;
   localparam int QW = 12;

   logic            clk;
   logic            aresetn;
   logic [NP-1:0]   pkt_avail;
   logic [NP*LW-1:0] head_len;
   logic [NP*QW-1:0] quantum;
   logic            sched_valid;
   logic [1:0]      sched_port;
   logic [LW-1:0]   sched_len;
   logic            sched_ready;
   logic            pkt_done;
   logic            proto_err;

   p4_router_ingress_dwrr_sched #(
      .NUM_PORTS    (NP),
      .LEN_WIDTH    (LW),
      .QUANTUM_WIDTH(QW),
      .DEFICIT_WIDTH(14)
   ) dut (
      .clk        (clk),
      .aresetn    (aresetn),
      .pkt_avail  (pkt_avail),
      .head_len   (head_len),
      .quantum    (quantum),
      .sched_valid(sched_valid),
      .sched_port (sched_port),
      .sched_len  (sched_len),
      .sched_ready(sched_ready),
      .pkt_done   (pkt_done),
      .proto_err  (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    port;
      logic [LW-1:0] len;
   } grant_t;

   grant_t exp_q[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the active edge; pkt_done is a one-cycle pulse.
   task automatic tick();
      @(posedge clk);
      #1;
      pkt_done = 1'b0;
   endtask

   task automatic set_len(input int p, input int l);
      head_len[p*LW +: LW] = LW'(l);
   endtask

   task automatic set_q(input int p, input int q);
      quantum[p*QW +: QW] = QW'(q);
   endtask

   task automatic push(input int p, input int l);
      grant_t g;
      g.port = 2'(p);
      g.len  = LW'(l);
      exp_q.push_back(g);
   endtask

   task automatic hold_reset(input string tag);
      aresetn     = 1'b0;
      sched_ready = 1'b0;
      pkt_done    = 1'b0;
      tick();
      tick();
      chk({tag, "_rst_valid"}, 32'(sched_valid), 32'd0);
      chk({tag, "_rst_port"}, 32'(sched_port), 32'd0);
      chk({tag, "_rst_len"}, 32'(sched_len), 32'd0);
      chk({tag, "_rst_err"}, 32'(proto_err), 32'd0);
   endtask

   task automatic wait_grant(input string tag, input int lat_exp, input int limit,
                             output logic [1:0] got);
      int n;
      grant_t e;
      n = 0;
      while (sched_valid !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(sched_valid), 32'd1);
      if (lat_exp >= 0) chk({tag, "_lat"}, 32'(n), 32'(lat_exp));
      e = exp_q.pop_front();
      chk({tag, "_port"}, 32'(sched_port), 32'(e.port));
      chk({tag, "_len"}, 32'(sched_len), 32'(e.len));
      got = sched_port;
   endtask

   task automatic accept(input string tag);
      sched_ready = 1'b1;
      tick();
      sched_ready = 1'b0;
      chk({tag, "_acc_idle"}, 32'(sched_valid), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] g;
      int cnt0;
      int cnt1;
      aresetn     = 1'b0;
      pkt_avail   = '0;
      head_len    = '0;
      quantum     = '0;
      sched_ready = 1'b0;
      pkt_done    = 1'b0;

      // 1: single backlogged port, then a failing CHECK after pkt_done.
      hold_reset("t1");
      for (int p = 0; p < NP; p++) set_q(p, 8);
      pkt_avail = 4'b0010;
      set_len(1, 5);
      aresetn = 1'b1;
      push(1, 5);
      wait_grant("t1_g0", 3, 30, g);
      accept("t1_g0");
      pkt_done = 1'b1;
      tick();
      chk("t1_done_err", 32'(proto_err), 32'd0);
      chk("t1_done_idle", 32'(sched_valid), 32'd0);
      push(1, 5);
      wait_grant("t1_g1", 6, 30, g);
      accept("t1_g1");

      // 2: ports 0 and 2 alternate.
      hold_reset("t2");
      for (int p = 0; p < NP; p++) begin
         set_q(p, 8);
         set_len(p, 8);
      end
      pkt_avail = 4'b0101;
      aresetn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push((i % 2 == 0) ? 0 : 2, 8);
         wait_grant($sformatf("t2_g%0d", i), (i == 0) ? 2 : 5, 40, g);
         accept($sformatf("t2_g%0d", i));
         pkt_done = 1'b1;
      end
      tick();

      // 3: 2:1 quanta, p0 gets back-to-back pairs.
      hold_reset("t3");
      for (int p = 0; p < NP; p++) begin
         set_q(p, 8);
         set_len(p, 8);
      end
      set_q(0, 16);
      pkt_avail = 4'b0011;
      aresetn = 1'b1;
      cnt0 = 0;
      cnt1 = 0;
      for (int i = 0; i < 30; i++) begin
         int lat;
         lat = (i % 3 == 0) ? ((i == 0) ? 2 : 6) : ((i % 3 == 1) ? 2 : 4);
         push((i % 3 == 2) ? 1 : 0, 8);
         wait_grant($sformatf("t3_g%0d", i), lat, 40, g);
         if (g == 2'd0) cnt0++;
         if (g == 2'd1) cnt1++;
         accept($sformatf("t3_g%0d", i));
         pkt_done = 1'b1;
      end
      tick();
      chk("t3_cnt0", 32'(cnt0), 32'd20);
      chk("t3_cnt1", 32'(cnt1), 32'd10);

      // 4: long packet needs three visits; residual deficit is exactly 4.
      hold_reset("t4");
      for (int p = 0; p < NP; p++) set_q(p, 8);
      pkt_avail = 4'b1000;
      set_len(3, 20);
      aresetn = 1'b1;
      push(3, 20);
      wait_grant("t4_g0", 15, 40, g);
      accept("t4_g0");
      set_len(3, 4);
      pkt_done = 1'b1;
      push(3, 4);
      wait_grant("t4_g1", 2, 40, g);
      accept("t4_g1");
      set_len(3, 1);
      pkt_done = 1'b1;
      push(3, 1);
      wait_grant("t4_g2", 7, 40, g);
      accept("t4_g2");

      // 5: emptied port forfeits its deficit; zero quantum starves a port.
      hold_reset("t5");
      for (int p = 0; p < NP; p++) set_q(p, 8);
      pkt_avail = 4'b0001;
      set_len(0, 2);
      aresetn = 1'b1;
      push(0, 2);
      wait_grant("t5_g0", 2, 40, g);
      accept("t5_g0");
      pkt_avail = 4'b0000;
      pkt_done  = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("t5_empty_valid", 32'(sched_valid), 32'd0);
      chk("t5_empty_err", 32'(proto_err), 32'd0);
      set_len(0, 8);
      pkt_avail = 4'b0001;
      push(0, 8);
      wait_grant("t5_g1", -1, 40, g);
      accept("t5_g1");
      set_len(0, 6);
      pkt_done = 1'b1;
      push(0, 6);
      wait_grant("t5_g2", 7, 40, g);
      accept("t5_g2");
      set_q(0, 0);
      pkt_done = 1'b1;
      for (int i = 0; i < 40; i++) tick();
      chk("t5_starve_valid", 32'(sched_valid), 32'd0);
      chk("t5_starve_err", 32'(proto_err), 32'd0);

      // 6: OFFER stability, protocol errors, async reset mid-offer.
      hold_reset("t6");
      for (int p = 0; p < NP; p++) set_q(p, 8);
      pkt_avail = 4'b0100;
      set_len(2, 3);
      aresetn = 1'b1;
      push(2, 3);
      wait_grant("t6_g0", 4, 40, g);
      set_len(2, 9);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("t6_hold%0d_valid", i), 32'(sched_valid), 32'd1);
         chk($sformatf("t6_hold%0d_port", i), 32'(sched_port), 32'd2);
         chk($sformatf("t6_hold%0d_len", i), 32'(sched_len), 32'd3);
      end
      pkt_done = 1'b1;
      tick();
      chk("t6_err_pulse", 32'(proto_err), 32'd1);
      chk("t6_err_valid", 32'(sched_valid), 32'd1);
      tick();
      chk("t6_err_clear", 32'(proto_err), 32'd0);
      chk("t6_err_len", 32'(sched_len), 32'd3);
      sched_ready = 1'b1;
      pkt_done    = 1'b1;
      tick();
      sched_ready = 1'b0;
      chk("t6_hs_err", 32'(proto_err), 32'd1);
      chk("t6_hs_idle", 32'(sched_valid), 32'd0);
      tick();
      chk("t6_busy_hold", 32'(sched_valid), 32'd0);
      set_len(2, 3);
      pkt_done = 1'b1;
      push(2, 3);
      wait_grant("t6_g1", 2, 40, g);
      aresetn = 1'b0;
      #1;
      chk("t6_async_valid", 32'(sched_valid), 32'd0);
      chk("t6_async_len", 32'(sched_len), 32'd0);
      tick();
      tick();
      set_len(2, 13);
      aresetn = 1'b1;
      push(2, 13);
      wait_grant("t6_g2", 9, 40, g);
      accept("t6_g2");

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
